// File: rtl/mac_tx_framer_if.sv
// Payload byte stream into the framer and GMII-style transmit bus out of it.
// The master side is the upstream source and bus observer. The slave side is the framer.
interface mac_tx_framer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_error;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, tx_enable, tx_data, tx_error, busy, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, tx_enable, tx_data, tx_error, busy, frame_done
    );
endinterface

// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: preamble, SFD, payload, zero pad, FCS, inter-frame gap.
// Also contains crc32, the reflected IEEE 802.3 CRC that the framer uses for the FCS.

// Byte-wide reflected CRC-32 (poly 0xEDB88320, init all-ones, result inverted).
module crc32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] result
);
    logic [31:0] r_crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'h000000, d};
        for (int unsigned i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        end
        return v;
    endfunction

    // CRC register: clear has priority over accumulating a byte.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_crc <= '1;
        end else if (enable) begin
            r_crc <= crc_byte(r_crc, data);
        end
    end

    assign result = ~r_crc;
endmodule

module mac_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_DATA_BYTES = 60,
    parameter int IFG_BYTES      = 12
) (
    input  logic             clock,
    input  logic             reset,
    mac_tx_framer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [11:0] MIN_LEN  = 12'(MIN_DATA_BYTES);

    state_t      r_state, w_state_nxt;
    logic [10:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_fcs_sr, w_fcs_nxt;
    logic        r_tx_en, w_tx_en_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_tx_er, w_tx_er_nxt;
    logic        r_done, w_done_nxt;
    logic        r_busy, w_busy_nxt;

    logic        w_crc_clr, w_crc_en;
    logic [7:0]  w_crc_data;
    logic [31:0] w_crc;
    logic [11:0] w_cnt_p1;
    logic [10:0] w_cnt_sat;

    assign w_cnt_p1  = {1'b0, r_cnt} + 12'd1;
    assign w_cnt_sat = (r_cnt == '1) ? r_cnt : r_cnt + 11'd1;

    crc32 u_crc (
        .clock  (clock),
        .clear  (reset | w_crc_clr),
        .enable (w_crc_en),
        .data   (w_crc_data),
        .result (w_crc)
    );

    // The state names the byte being prepared; every wire output is registered, so a
    // state's byte appears one cycle later. The FCS state reads the CRC on its first
    // cycle, after the final payload/pad byte has been folded in.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_fcs_nxt     = r_fcs_sr;
        w_tx_en_nxt   = 1'b0;
        w_tx_data_nxt = 8'h00;
        w_tx_er_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_crc_data    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt   = (PREAMBLE_BYTES > 1) ? S_PREAMBLE : S_SFD;
                    w_cnt_nxt     = 11'd1;
                    w_tx_en_nxt   = 1'b1;
                    w_tx_data_nxt = 8'h55;
                end
            end
            S_PREAMBLE: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = 8'h55;
                w_crc_clr     = 1'b1;
                if (r_cnt >= PRE_LAST) begin
                    w_state_nxt = S_SFD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 11'd1;
                end
            end
            S_SFD: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = 8'hD5;
                w_crc_clr     = 1'b1;
                w_state_nxt   = S_PAYLOAD;
                w_cnt_nxt     = '0;
            end
            S_PAYLOAD: begin
                w_tx_en_nxt = 1'b1;
                if (bus.in_valid) begin
                    w_tx_data_nxt = bus.in_data;
                    w_crc_en      = 1'b1;
                    w_crc_data    = bus.in_data;
                    w_cnt_nxt     = w_cnt_sat;
                    if (bus.in_last) begin
                        if (w_cnt_p1 < MIN_LEN) begin
                            w_state_nxt = S_PAD;
                        end else begin
                            w_state_nxt = S_FCS;
                            w_cnt_nxt   = '0;
                        end
                    end
                end else begin
                    w_tx_er_nxt = 1'b1;
                    w_state_nxt = S_IFG;
                    w_cnt_nxt   = '0;
                end
            end
            S_PAD: begin
                w_tx_en_nxt = 1'b1;
                w_crc_en    = 1'b1;
                if (w_cnt_p1 >= MIN_LEN) begin
                    w_state_nxt = S_FCS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_sat;
                end
            end
            S_FCS: begin
                w_tx_en_nxt = 1'b1;
                if (r_cnt == 11'd0) begin
                    w_tx_data_nxt = w_crc[7:0];
                    w_fcs_nxt     = {8'h00, w_crc[31:8]};
                end else begin
                    w_tx_data_nxt = r_fcs_sr[7:0];
                    w_fcs_nxt     = {8'h00, r_fcs_sr[31:8]};
                end
                if (r_cnt == 11'd3) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IFG;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 11'd1;
                end
            end
            S_IFG: begin
                if (r_cnt >= IFG_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 11'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_fcs_sr  <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
            r_tx_er   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fcs_sr  <= w_fcs_nxt;
            r_tx_en   <= w_tx_en_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_er   <= w_tx_er_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign bus.in_ready   = (r_state == S_PAYLOAD);
    assign bus.tx_enable  = r_tx_en;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_error   = r_tx_er;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: expected wire bytes are queued when a frame is offered and
// checked against the captured transmit bus once the frame has gone out.
module tb_mac_tx_framer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    mac_tx_framer_if bus ();

    mac_tx_framer #(
        .PREAMBLE_BYTES (7),
        .MIN_DATA_BYTES (60),
        .IFG_BYTES      (12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [8:0] src_q[$];       // {last, data} still to be offered upstream
    logic [8:0] exp_q[$];       // {error, data} expected on the wire
    logic [8:0] cap_q[$];       // {error, data} captured while tx_enable=1
    int         done_idx_q[$];  // captured byte position of each frame_done pulse
    int         gaps_q[$];      // idle-cycle runs preceding each burst after the first
    int         hs_cnt, en_cnt, idle_run;
    bit         seen_burst;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h000000, b[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic push_frame(input logic [7:0] pl[$], input bit underrun);
        logic [7:0]  body[$];
        logic [31:0] f;
        logic        l;
        foreach (pl[i]) begin
            l = !underrun && (i == pl.size() - 1);
            src_q.push_back({l, pl[i]});
        end
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        foreach (pl[i]) exp_q.push_back({1'b0, pl[i]});
        if (underrun) begin
            exp_q.push_back(9'h100);
        end else begin
            body = pl;
            while (body.size() < 60) begin
                body.push_back(8'h00);
                exp_q.push_back(9'h000);
            end
            f = ref_crc(body);
            exp_q.push_back({1'b0, f[7:0]});
            exp_q.push_back({1'b0, f[15:8]});
            exp_q.push_back({1'b0, f[23:16]});
            exp_q.push_back({1'b0, f[31:24]});
        end
    endtask

    // One clock: observe the bus at the falling edge, then drive the next input byte.
    task automatic tick();
        bit hs;
        @(negedge clock);
        hs = bus.in_valid && bus.in_ready;
        if (hs) hs_cnt++;
        if (bus.tx_enable === 1'b1) begin
            cap_q.push_back({bus.tx_error, bus.tx_data});
            en_cnt++;
            if (seen_burst && idle_run > 0) gaps_q.push_back(idle_run);
            idle_run   = 0;
            seen_burst = 1'b1;
        end else begin
            idle_run++;
        end
        if (bus.frame_done === 1'b1) done_idx_q.push_back(cap_q.size());
        @(posedge clock);
        #1;
        if (hs) void'(src_q.pop_front());
        if (src_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src_q[0][7:0];
            bus.in_last  = src_q[0][8];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'h00;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic clear_capture();
        exp_q.delete();
        cap_q.delete();
        done_idx_q.delete();
        gaps_q.delete();
        hs_cnt     = 0;
        en_cnt     = 0;
        idle_run   = 0;
        seen_burst = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (src_q.size() == 0 && bus.busy === 1'b0 && bus.tx_enable === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus.tx_enable !== 1'b0) begin n_bad++; $display("FAIL rst_tx_enable got %b want 0", bus.tx_enable); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
        n_cmp++; if (bus.tx_error !== 1'b0) begin n_bad++; $display("FAIL rst_tx_error got %b want 0", bus.tx_error); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_one_byte();
        logic [7:0] pl[$];
        logic [8:0] e, a;
        bit ok;
        clear_capture();
        pl.push_back(8'hAB);
        push_frame(pl, 1'b0);
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_timeout got busy want idle"); end
        n_cmp++; if (en_cnt != 72) begin n_bad++; $display("FAIL t1_enable_cycles got %0d want 72", en_cnt); end
        n_cmp++; if (done_idx_q.size() != 1 || done_idx_q[0] != 72) begin n_bad++; $display("FAIL t1_frame_done got %0d pulses want one at byte 72", done_idx_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t1_wire_byte got %h want %h", a, e); end
        end
    endtask

    task automatic test_sixty();
        logic [7:0] pl[$];
        logic [7:0] chk[$];
        logic [31:0] res;
        logic [8:0] e, a;
        bit ok;
        clear_capture();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        push_frame(pl, 1'b0);
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t2_timeout got busy want idle"); end
        n_cmp++; if (en_cnt != 72) begin n_bad++; $display("FAIL t2_enable_cycles got %0d want 72", en_cnt); end
        if (cap_q.size() >= 72) begin
            for (int i = 8; i < 72; i++) chk.push_back(cap_q[i][7:0]);
        end
        res = ref_crc(chk);
        n_cmp++; if (res !== 32'h2144DF1C) begin n_bad++; $display("FAIL t2_crc_residue got %h want 2144df1c", res); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t2_wire_byte got %h want %h", a, e); end
        end
    endtask

    task automatic test_long();
        logic [7:0] pl[$];
        logic [8:0] e, a;
        bit ok;
        clear_capture();
        for (int i = 0; i < 100; i++) pl.push_back(8'($urandom_range(0, 255)));
        push_frame(pl, 1'b0);
        wait_idle(600, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t3_timeout got busy want idle"); end
        n_cmp++; if (en_cnt != 112) begin n_bad++; $display("FAIL t3_enable_cycles got %0d want 112", en_cnt); end
        n_cmp++; if (hs_cnt != 100) begin n_bad++; $display("FAIL t3_handshakes got %0d want 100", hs_cnt); end
        n_cmp++; if (done_idx_q.size() != 1 || done_idx_q[0] != 112) begin n_bad++; $display("FAIL t3_frame_done got %0d pulses want one at byte 112", done_idx_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t3_wire_byte got %h want %h", a, e); end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        logic [8:0] e, a;
        bit ok;
        int guard;
        clear_capture();
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'hA0 + i));
        push_frame(pl, 1'b1);
        guard = 0;
        while (src_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        n_cmp++; if (src_q.size() != 0) begin n_bad++; $display("FAIL t4_drain_timeout got %0d left want 0", src_q.size()); end
        repeat (3) tick();
        for (int i = 0; i < 8; i++) pl2.push_back(8'($urandom_range(0, 255)));
        push_frame(pl2, 1'b0);
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_timeout got busy want idle"); end
        n_cmp++; if (gaps_q.size() != 1 || gaps_q[0] != 12) begin n_bad++; $display("FAIL t4_idle_gap got %0d runs first %0d want one run of 12", gaps_q.size(), (gaps_q.size() > 0) ? gaps_q[0] : -1); end
        n_cmp++; if (done_idx_q.size() != 1 || done_idx_q[0] != 101) begin n_bad++; $display("FAIL t4_frame_done got %0d pulses want one at byte 101", done_idx_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t4_wire_byte got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        logic [8:0] e, a;
        bit ok;
        clear_capture();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 70; i++) pl2.push_back(8'($urandom_range(0, 255)));
        push_frame(pl, 1'b0);
        push_frame(pl2, 1'b0);
        wait_idle(800, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t5_timeout got busy want idle"); end
        n_cmp++; if (gaps_q.size() != 1 || gaps_q[0] != 12) begin n_bad++; $display("FAIL t5_idle_gap got %0d runs first %0d want one run of 12", gaps_q.size(), (gaps_q.size() > 0) ? gaps_q[0] : -1); end
        n_cmp++; if (done_idx_q.size() != 2) begin n_bad++; $display("FAIL t5_frame_done got %0d pulses want 2", done_idx_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t5_wire_byte got %h want %h", a, e); end
        end
    endtask

    task automatic test_reset_in_pad();
        logic [7:0] pl[$];
        logic [7:0] pl2[$];
        logic [8:0] e, a;
        bit ok;
        int guard;
        clear_capture();
        pl.push_back(8'h3C);
        push_frame(pl, 1'b0);
        guard = 0;
        while (cap_q.size() < 20 && guard < 200) begin
            tick();
            guard++;
        end
        n_cmp++; if (cap_q.size() < 20) begin n_bad++; $display("FAIL t6_reach_pad got %0d bytes want 20", cap_q.size()); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (bus.tx_enable !== 1'b0) begin n_bad++; $display("FAIL t6_tx_enable_after_reset got %b want 0", bus.tx_enable); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t6_busy_after_reset got %b want 0", bus.busy); end
        n_cmp++; if (done_idx_q.size() != 0) begin n_bad++; $display("FAIL t6_no_done_on_abort got %0d pulses want 0", done_idx_q.size()); end
        clear_capture();
        for (int i = 0; i < 3; i++) pl2.push_back(8'(8'h70 + i));
        push_frame(pl2, 1'b0);
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_timeout got busy want idle"); end
        n_cmp++; if (done_idx_q.size() != 1 || done_idx_q[0] != 72) begin n_bad++; $display("FAIL t6_frame_done got %0d pulses want one at byte 72", done_idx_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (cap_q.size() > 0) ? cap_q.pop_front() : 9'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL t6_wire_byte got %h want %h", a, e); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        clear_capture();
        test_reset();
        test_one_byte();
        test_sixty();
        test_long();
        test_underrun();
        test_back_to_back();
        test_reset_in_pad();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
